midi_voice_controller: RTL and testbench

//  Parses a MIDI byte stream (one byte per rx_valid strobe from the UART receiver) into monophonic

---
 rtl/midi_voice_controller.sv | 246 ++++++++++++++++++++++++
 tb/tb_midi_voice_controller.sv | 473 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_voice_controller.sv
// -----------------------------------------------------------------------------
// midi_voice_controller
//
// Purpose:
//   Turns the byte stream from a MIDI UART receiver into monophonic note/gate
//   control for a single synth voice. Handles running status, interleaved
//   real-time bytes, SysEx skipping and a channel filter. When a note-on
//   arrives while the gate is already high, the gate can be dropped for a
//   short programmable gap so that the voice envelope retriggers.
//
// Parameters:
//   CHANNEL        MIDI channel (0-15) accepted when OMNI = 0
//   OMNI           1 = act on channel messages from every channel
//   RETRIG_CYCLES  gate-low cycles inserted on a note-on while the gate is
//                  high (0 = legato, gate stays high)
//
// Ports:
//   clk         in   1  system clock
//   rst_n       in   1  asynchronous active-low reset
//   rx_data     in   8  received MIDI byte, qualified by rx_valid
//   rx_valid    in   1  one-cycle strobe per received byte
//   note        out  8  current note number (bit 7 always 0)
//   gate        out  1  note held (voice enable)
//   velocity    out  7  velocity of the last accepted note-on
//   note_event  out  1  one-cycle pulse per accepted note-on / note-off
// -----------------------------------------------------------------------------
module midi_voice_controller #(
    parameter logic [3:0]  CHANNEL       = 4'd0,
    parameter bit          OMNI          = 1'b0,
    parameter int unsigned RETRIG_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] note,
    output logic       gate,
    output logic [6:0] velocity,
    output logic       note_event
);

    // Counter just wide enough to hold RETRIG_CYCLES (at least one bit).
    localparam int unsigned       CNT_W       = (RETRIG_CYCLES > 1) ? $clog2(RETRIG_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0]  RETRIG_LOAD = CNT_W'(RETRIG_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,     // no running status: data bytes dropped
        ST_WAIT_D1,  // running status valid, expecting first data byte
        ST_WAIT_D2,  // first data byte held, expecting second
        ST_SYSEX     // inside a system-exclusive dump
    } state_t;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t           r_state;
    logic [7:0]       r_status;      // running status, 8'h00 = none
    logic [6:0]       r_d1;          // first data byte of a two-byte message
    logic [6:0]       r_note;
    logic             r_gate;
    logic [6:0]       r_velocity;
    logic             r_note_event;
    logic [CNT_W-1:0] r_retrig_cnt;  // remaining gate-low cycles of a retrigger gap

    // -------------------------------------------------------------------------
    // Byte classification
    // -------------------------------------------------------------------------
    logic w_is_realtime;     // 0xF8-0xFF
    logic w_is_syscommon;    // 0xF0-0xF7
    logic w_is_chan_status;  // 0x80-0xEF
    logic w_one_data;        // running status is 0xC_/0xD_ (single data byte)

    assign w_is_realtime    = (rx_data[7:3] == 5'b11111);
    assign w_is_syscommon   = (rx_data[7:3] == 5'b11110);
    assign w_is_chan_status = rx_data[7] && (rx_data[7:4] != 4'hF);
    assign w_one_data       = (r_status[7:5] == 3'b110);

    // -------------------------------------------------------------------------
    // Parser FSM: next state, running status and message completion
    // -------------------------------------------------------------------------
    state_t     w_state_nxt;
    logic [7:0] w_status_nxt;
    logic       w_d1_load;
    logic       w_msg_done;
    logic [6:0] w_msg_d1;
    logic [6:0] w_msg_d2;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_status_nxt = r_status;
        w_d1_load    = 1'b0;
        w_msg_done   = 1'b0;
        w_msg_d1     = r_d1;
        w_msg_d2     = 7'd0;

        // Real-time bytes fall through untouched: they may land anywhere,
        // even between the two data bytes of a message.
        if (rx_valid && !w_is_realtime) begin
            if (w_is_syscommon) begin
                w_status_nxt = 8'h00;
                w_state_nxt  = (rx_data == 8'hF0) ? ST_SYSEX : ST_IDLE;
            end else if (w_is_chan_status) begin
                // Also abandons any half-received message in WAIT_D2.
                w_status_nxt = rx_data;
                w_state_nxt  = ST_WAIT_D1;
            end else begin
                case (r_state)
                    ST_WAIT_D1: begin
                        w_d1_load = 1'b1;
                        if (w_one_data) begin
                            w_msg_done = 1'b1;
                            w_msg_d1   = rx_data[6:0];
                        end else begin
                            w_state_nxt = ST_WAIT_D2;
                        end
                    end
                    ST_WAIT_D2: begin
                        w_msg_done  = 1'b1;
                        w_msg_d2    = rx_data[6:0];
                        w_state_nxt = ST_WAIT_D1;  // running status
                    end
                    default: begin
                        // IDLE and SYSEX drop data bytes.
                    end
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // Message decode
    // -------------------------------------------------------------------------
    logic [3:0] w_cmd;
    logic       w_chan_ok;
    logic       w_note_on;
    logic       w_note_off;
    logic       w_all_off;
    logic       w_gap_active;

    assign w_cmd        = r_status[7:4];
    assign w_chan_ok    = OMNI || (r_status[3:0] == CHANNEL);
    assign w_note_on    = w_msg_done && w_chan_ok && (w_cmd == 4'h9) && (w_msg_d2 != 7'd0);
    assign w_note_off   = w_msg_done && w_chan_ok &&
                          ((w_cmd == 4'h8) || ((w_cmd == 4'h9) && (w_msg_d2 == 7'd0)));
    // Controller 123 = all notes off, 120 = all sound off.
    assign w_all_off    = w_msg_done && w_chan_ok && (w_cmd == 4'hB) &&
                          ((w_msg_d1 == 7'd123) || (w_msg_d1 == 7'd120));
    assign w_gap_active = (r_retrig_cnt != '0);

    // -------------------------------------------------------------------------
    // Voice control next-state
    // -------------------------------------------------------------------------
    logic [6:0]       w_note_nxt;
    logic             w_gate_nxt;
    logic [6:0]       w_vel_nxt;
    logic             w_event_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    always_comb begin
        w_note_nxt  = r_note;
        w_gate_nxt  = r_gate;
        w_vel_nxt   = r_velocity;
        w_event_nxt = 1'b0;
        w_cnt_nxt   = r_retrig_cnt;

        // Retrigger gap countdown; gate comes back on the last step.
        if (w_gap_active) begin
            w_cnt_nxt = r_retrig_cnt - CNT_W'(1);
            if (r_retrig_cnt == CNT_W'(1)) begin
                w_gate_nxt = 1'b1;
            end
        end

        // Message actions override the countdown, so a note-off landing on
        // the expiry cycle keeps the gate low.
        if (w_note_on) begin
            w_note_nxt  = w_msg_d1;
            w_vel_nxt   = w_msg_d2;
            w_event_nxt = 1'b1;
            // A note-on inside a running gap counts as "gate high" and
            // restarts the gap.
            if ((r_gate || w_gap_active) && (RETRIG_CYCLES > 0)) begin
                w_gate_nxt = 1'b0;
                w_cnt_nxt  = RETRIG_LOAD;
            end else begin
                w_gate_nxt = 1'b1;
            end
        end else if (w_note_off) begin
            // Last-note priority: releasing an older key does nothing.
            if (w_msg_d1 == r_note) begin
                w_gate_nxt  = 1'b0;
                w_cnt_nxt   = '0;
                w_event_nxt = 1'b1;
            end
        end else if (w_all_off) begin
            w_gate_nxt = 1'b0;
            w_cnt_nxt  = '0;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_status <= 8'h00;
            r_d1     <= 7'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_status <= w_status_nxt;
            if (w_d1_load) begin
                r_d1 <= rx_data[6:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_note       <= 7'd0;
            r_gate       <= 1'b0;
            r_velocity   <= 7'd0;
            r_note_event <= 1'b0;
            r_retrig_cnt <= '0;
        end else begin
            r_note       <= w_note_nxt;
            r_gate       <= w_gate_nxt;
            r_velocity   <= w_vel_nxt;
            r_note_event <= w_event_nxt;
            r_retrig_cnt <= w_cnt_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs (all straight from registers)
    // -------------------------------------------------------------------------
    assign note       = {1'b0, r_note};
    assign gate       = r_gate;
    assign velocity   = r_velocity;
    assign note_event = r_note_event;

endmodule

// File: tb/tb_midi_voice_controller.sv
// -----------------------------------------------------------------------------
// tb_midi_voice_controller
//
// Self-checking bench. Instance u_dut_a uses the default parameters
// (CHANNEL=0, OMNI=0, RETRIG_CYCLES=1); u_dut_b (CHANNEL=5, OMNI=1,
// RETRIG_CYCLES=3) shares the byte stream and is checked for multi-cycle
// retrigger gaps. Each scenario builds a per-cycle step list; expected output
// snapshots are queued as the byte is driven and compared half a cycle after
// the edge that samples it.
// -----------------------------------------------------------------------------
module tb_midi_voice_controller;

    typedef struct packed {
        logic [7:0] note;
        logic       gate;
        logic [6:0] vel;
        logic       ev;
    } snap_t;

    typedef struct packed {
        logic       v;     // drive rx_valid this cycle
        logic [7:0] d;     // byte
        logic       chk;   // compare outputs after this cycle
        snap_t      want;
    } step_t;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data  = 8'h00;

    logic [7:0] a_note, b_note;
    logic       a_gate, b_gate;
    logic [6:0] a_vel, b_vel;
    logic       a_ev, b_ev;

    int    n_checks = 0;
    int    n_errors = 0;
    snap_t sb[$];
    step_t steps[$];

    always #5 clk = ~clk;

    midi_voice_controller u_dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .note       (a_note),
        .gate       (a_gate),
        .velocity   (a_vel),
        .note_event (a_ev)
    );

    midi_voice_controller #(
        .CHANNEL       (4'd5),
        .OMNI          (1'b1),
        .RETRIG_CYCLES (3)
    ) u_dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .note       (b_note),
        .gate       (b_gate),
        .velocity   (b_vel),
        .note_event (b_ev)
    );

    function automatic snap_t sn(input logic [7:0] n, input logic g, input logic [6:0] v, input logic e);
        return {n, g, v, e};
    endfunction

    function automatic step_t tx(input logic [7:0] d);
        return {1'b1, d, 1'b0, 17'd0};
    endfunction

    function automatic step_t txc(input logic [7:0] d, input snap_t e);
        return {1'b1, d, 1'b1, e};
    endfunction

    function automatic step_t idc(input snap_t e);
        return {1'b0, 8'h00, 1'b1, e};
    endfunction

    function automatic snap_t obs_a();
        return {a_note, a_gate, a_vel, a_ev};
    endfunction

    function automatic snap_t obs_b();
        return {b_note, b_gate, b_vel, b_ev};
    endfunction

    // -------------------------------------------------------------------------
    task automatic test_reset();
        snap_t got;
        #2 rst_n = 1'b0;
        #1;
        got = obs_a();
        n_checks++;
        if (got !== snap_t'(0)) begin
            n_errors++;
            $display("FAIL reset_a: got %h, expected 0", got);
        end
        got = obs_b();
        n_checks++;
        if (got !== snap_t'(0)) begin
            n_errors++;
            $display("FAIL reset_b: got %h, expected 0", got);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_note_on();
        snap_t got, want;
        steps.delete();
        steps.push_back(txc(8'h90, sn(8'h00, 1'b0, 7'h00, 1'b0)));
        steps.push_back(txc(8'h3C, sn(8'h00, 1'b0, 7'h00, 1'b0)));
        steps.push_back(txc(8'h64, sn(8'h3C, 1'b1, 7'h64, 1'b1)));
        steps.push_back(idc(sn(8'h3C, 1'b1, 7'h64, 1'b0)));
        foreach (steps[i]) begin
            rx_data  = steps[i].d;
            rx_valid = steps[i].v;
            if (steps[i].chk) sb.push_back(steps[i].want);
            @(negedge clk);
            rx_valid = 1'b0;
            if (steps[i].chk) begin
                want = sb.pop_front();
                got  = obs_a();
                n_checks++;
                if (got !== want) begin
                    n_errors++;
                    $display("FAIL note_on step %0d: got note=%h gate=%b vel=%h ev=%b, expected note=%h gate=%b vel=%h ev=%b",
                             i, got.note, got.gate, got.vel, got.ev, want.note, want.gate, want.vel, want.ev);
                end
            end
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_running_status();
        snap_t got, want;
        steps.delete();
        steps.push_back(tx(8'h40));
        steps.push_back(txc(8'h50, sn(8'h40, 1'b0, 7'h50, 1'b1)));  // one-cycle gap
        steps.push_back(idc(sn(8'h40, 1'b1, 7'h50, 1'b0)));
        steps.push_back(idc(sn(8'h40, 1'b1, 7'h50, 1'b0)));
        steps.push_back(tx(8'h40));
        steps.push_back(txc(8'h00, sn(8'h40, 1'b0, 7'h50, 1'b1)));  // velocity-0 note-off
        steps.push_back(idc(sn(8'h40, 1'b0, 7'h50, 1'b0)));
        foreach (steps[i]) begin
            rx_data  = steps[i].d;
            rx_valid = steps[i].v;
            if (steps[i].chk) sb.push_back(steps[i].want);
            @(negedge clk);
            rx_valid = 1'b0;
            if (steps[i].chk) begin
                want = sb.pop_front();
                got  = obs_a();
                n_checks++;
                if (got !== want) begin
                    n_errors++;
                    $display("FAIL running_status step %0d: got note=%h gate=%b vel=%h ev=%b, expected note=%h gate=%b vel=%h ev=%b",
                             i, got.note, got.gate, got.vel, got.ev, want.note, want.gate, want.vel, want.ev);
                end
            end
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_last_note();
        snap_t got, want;
        steps.delete();
        steps.push_back(tx(8'h90));
        steps.push_back(tx(8'h3C));
        steps.push_back(txc(8'h64, sn(8'h3C, 1'b1, 7'h64, 1'b1)));
        steps.push_back(tx(8'h90));
        steps.push_back(tx(8'h40));
        steps.push_back(txc(8'h64, sn(8'h40, 1'b0, 7'h64, 1'b1)));
        steps.push_back(idc(sn(8'h40, 1'b1, 7'h64, 1'b0)));
        steps.push_back(tx(8'h80));
        steps.push_back(tx(8'h3C));
        steps.push_back(txc(8'h00, sn(8'h40, 1'b1, 7'h64, 1'b0)));  // older key: ignored
        steps.push_back(tx(8'h80));
        steps.push_back(tx(8'h40));
        steps.push_back(txc(8'h00, sn(8'h40, 1'b0, 7'h64, 1'b1)));
        steps.push_back(idc(sn(8'h40, 1'b0, 7'h64, 1'b0)));
        foreach (steps[i]) begin
            rx_data  = steps[i].d;
            rx_valid = steps[i].v;
            if (steps[i].chk) sb.push_back(steps[i].want);
            @(negedge clk);
            rx_valid = 1'b0;
            if (steps[i].chk) begin
                want = sb.pop_front();
                got  = obs_a();
                n_checks++;
                if (got !== want) begin
                    n_errors++;
                    $display("FAIL last_note step %0d: got note=%h gate=%b vel=%h ev=%b, expected note=%h gate=%b vel=%h ev=%b",
                             i, got.note, got.gate, got.vel, got.ev, want.note, want.gate, want.vel, want.ev);
                end
            end
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_realtime();
        snap_t got, want;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        steps.delete();
        steps.push_back(tx(8'h90));
        steps.push_back(tx(8'hF8));
        steps.push_back(tx(8'h3C));
        steps.push_back(txc(8'hFE, sn(8'h00, 1'b0, 7'h00, 1'b0)));
        steps.push_back(txc(8'h64, sn(8'h3C, 1'b1, 7'h64, 1'b1)));
        steps.push_back(idc(sn(8'h3C, 1'b1, 7'h64, 1'b0)));
        steps.push_back(tx(8'h80));
        steps.push_back(tx(8'h3C));
        steps.push_back(txc(8'h00, sn(8'h3C, 1'b0, 7'h64, 1'b1)));
        // SysEx then end-of-exclusive: running status gone, data ignored.
        steps.push_back(tx(8'hF0));
        steps.push_back(tx(8'h01));
        steps.push_back(tx(8'h02));
        steps.push_back(tx(8'hF7));
        steps.push_back(tx(8'h3C));
        steps.push_back(txc(8'h64, sn(8'h3C, 1'b0, 7'h64, 1'b0)));
        steps.push_back(idc(sn(8'h3C, 1'b0, 7'h64, 1'b0)));
        // SysEx left directly by a channel status byte.
        steps.push_back(tx(8'hF0));
        steps.push_back(tx(8'h3C));
        steps.push_back(txc(8'h64, sn(8'h3C, 1'b0, 7'h64, 1'b0)));
        steps.push_back(tx(8'h90));
        steps.push_back(tx(8'h3C));
        steps.push_back(txc(8'h64, sn(8'h3C, 1'b1, 7'h64, 1'b1)));
        steps.push_back(tx(8'h80));
        steps.push_back(tx(8'h3C));
        steps.push_back(txc(8'h00, sn(8'h3C, 1'b0, 7'h64, 1'b1)));
        foreach (steps[i]) begin
            rx_data  = steps[i].d;
            rx_valid = steps[i].v;
            if (steps[i].chk) sb.push_back(steps[i].want);
            @(negedge clk);
            rx_valid = 1'b0;
            if (steps[i].chk) begin
                want = sb.pop_front();
                got  = obs_a();
                n_checks++;
                if (got !== want) begin
                    n_errors++;
                    $display("FAIL realtime step %0d: got note=%h gate=%b vel=%h ev=%b, expected note=%h gate=%b vel=%h ev=%b",
                             i, got.note, got.gate, got.vel, got.ev, want.note, want.gate, want.vel, want.ev);
                end
            end
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_channel();
        snap_t got, want;
        steps.delete();
        steps.push_back(tx(8'h91));
        steps.push_back(tx(8'h3C));
        steps.push_back(txc(8'h64, sn(8'h3C, 1'b0, 7'h64, 1'b0)));  // other channel
        steps.push_back(tx(8'h90));
        steps.push_back(tx(8'h45));
        steps.push_back(txc(8'h70, sn(8'h45, 1'b1, 7'h70, 1'b1)));
        steps.push_back(tx(8'h81));
        steps.push_back(tx(8'h45));
        steps.push_back(txc(8'h00, sn(8'h45, 1'b1, 7'h70, 1'b0)));  // other channel
        steps.push_back(tx(8'hB1));
        steps.push_back(tx(8'h7B));
        steps.push_back(txc(8'h00, sn(8'h45, 1'b1, 7'h70, 1'b0)));  // other channel
        steps.push_back(tx(8'hB0));
        steps.push_back(tx(8'h07));
        steps.push_back(txc(8'h7F, sn(8'h45, 1'b1, 7'h70, 1'b0)));  // plain CC
        steps.push_back(tx(8'h7B));
        steps.push_back(txc(8'h00, sn(8'h45, 1'b0, 7'h70, 1'b0)));  // all notes off
        steps.push_back(tx(8'h90));
        steps.push_back(tx(8'h45));
        steps.push_back(txc(8'h70, sn(8'h45, 1'b1, 7'h70, 1'b1)));
        steps.push_back(tx(8'hB0));
        steps.push_back(tx(8'h78));
        steps.push_back(txc(8'h00, sn(8'h45, 1'b0, 7'h70, 1'b0)));  // all sound off
        foreach (steps[i]) begin
            rx_data  = steps[i].d;
            rx_valid = steps[i].v;
            if (steps[i].chk) sb.push_back(steps[i].want);
            @(negedge clk);
            rx_valid = 1'b0;
            if (steps[i].chk) begin
                want = sb.pop_front();
                got  = obs_a();
                n_checks++;
                if (got !== want) begin
                    n_errors++;
                    $display("FAIL channel step %0d: got note=%h gate=%b vel=%h ev=%b, expected note=%h gate=%b vel=%h ev=%b",
                             i, got.note, got.gate, got.vel, got.ev, want.note, want.gate, want.vel, want.ev);
                end
            end
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_parser_edges();
        snap_t got, want;
        steps.delete();
        steps.push_back(tx(8'hD0));
        steps.push_back(txc(8'h10, sn(8'h45, 1'b0, 7'h70, 1'b0)));
        steps.push_back(txc(8'h20, sn(8'h45, 1'b0, 7'h70, 1'b0)));
        steps.push_back(tx(8'hC0));
        steps.push_back(txc(8'h05, sn(8'h45, 1'b0, 7'h70, 1'b0)));
        // Status in WAIT_D2 abandons 90 3C; 45 is then only a first data byte.
        steps.push_back(tx(8'h90));
        steps.push_back(tx(8'h3C));
        steps.push_back(tx(8'h90));
        steps.push_back(txc(8'h45, sn(8'h45, 1'b0, 7'h70, 1'b0)));
        steps.push_back(txc(8'h66, sn(8'h45, 1'b1, 7'h66, 1'b1)));
        steps.push_back(tx(8'h45));
        steps.push_back(txc(8'h00, sn(8'h45, 1'b0, 7'h66, 1'b1)));
        foreach (steps[i]) begin
            rx_data  = steps[i].d;
            rx_valid = steps[i].v;
            if (steps[i].chk) sb.push_back(steps[i].want);
            @(negedge clk);
            rx_valid = 1'b0;
            if (steps[i].chk) begin
                want = sb.pop_front();
                got  = obs_a();
                n_checks++;
                if (got !== want) begin
                    n_errors++;
                    $display("FAIL parser_edges step %0d: got note=%h gate=%b vel=%h ev=%b, expected note=%h gate=%b vel=%h ev=%b",
                             i, got.note, got.gate, got.vel, got.ev, want.note, want.gate, want.vel, want.ev);
                end
            end
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_async_reset();
        snap_t got, want;
        steps.delete();
        steps.push_back(tx(8'h90));
        steps.push_back(tx(8'h3C));
        steps.push_back(txc(8'h64, sn(8'h3C, 1'b1, 7'h64, 1'b1)));
        steps.push_back(tx(8'h90));
        steps.push_back(tx(8'h3C));
        foreach (steps[i]) begin
            rx_data  = steps[i].d;
            rx_valid = steps[i].v;
            if (steps[i].chk) sb.push_back(steps[i].want);
            @(negedge clk);
            rx_valid = 1'b0;
            if (steps[i].chk) begin
                want = sb.pop_front();
                got  = obs_a();
                n_checks++;
                if (got !== want) begin
                    n_errors++;
                    $display("FAIL async_reset step %0d: got note=%h gate=%b vel=%h ev=%b, expected note=%h gate=%b vel=%h ev=%b",
                             i, got.note, got.gate, got.vel, got.ev, want.note, want.gate, want.vel, want.ev);
                end
            end
        end
        // Assert reset between clock edges: outputs must clear without a clock.
        #2 rst_n = 1'b0;
        #1;
        got = obs_a();
        n_checks++;
        if (got !== snap_t'(0)) begin
            n_errors++;
            $display("FAIL async_reset immediate: got %h, expected 0", got);
        end
        @(negedge clk);
        rst_n = 1'b1;
        steps.delete();
        steps.push_back(txc(8'h64, sn(8'h00, 1'b0, 7'h00, 1'b0)));  // IDLE drops it
        steps.push_back(idc(sn(8'h00, 1'b0, 7'h00, 1'b0)));
        foreach (steps[i]) begin
            rx_data  = steps[i].d;
            rx_valid = steps[i].v;
            if (steps[i].chk) sb.push_back(steps[i].want);
            @(negedge clk);
            rx_valid = 1'b0;
            if (steps[i].chk) begin
                want = sb.pop_front();
                got  = obs_a();
                n_checks++;
                if (got !== want) begin
                    n_errors++;
                    $display("FAIL async_reset_after step %0d: got note=%h gate=%b vel=%h ev=%b, expected note=%h gate=%b vel=%h ev=%b",
                             i, got.note, got.gate, got.vel, got.ev, want.note, want.gate, want.vel, want.ev);
                end
            end
        end
    endtask

    // -------------------------------------------------------------------------
    // Multi-cycle gap on u_dut_b: restart on note-on inside the gap, note-off
    // on the expiry cycle wins, and an uninterrupted gap lasts three cycles.
    task automatic test_back_to_back();
        snap_t got, want;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        steps.delete();
        steps.push_back(txc(8'h95, sn(8'h00, 1'b0, 7'h00, 1'b0)));
        steps.push_back(tx(8'h3C));
        steps.push_back(txc(8'h64, sn(8'h3C, 1'b1, 7'h64, 1'b1)));
        steps.push_back(tx(8'h40));
        steps.push_back(txc(8'h50, sn(8'h40, 1'b0, 7'h50, 1'b1)));
        steps.push_back(txc(8'h42, sn(8'h40, 1'b0, 7'h50, 1'b0)));
        steps.push_back(txc(8'h60, sn(8'h42, 1'b0, 7'h60, 1'b1)));  // restart gap
        steps.push_back(idc(sn(8'h42, 1'b0, 7'h60, 1'b0)));
        steps.push_back(txc(8'h42, sn(8'h42, 1'b0, 7'h60, 1'b0)));
        steps.push_back(txc(8'h00, sn(8'h42, 1'b0, 7'h60, 1'b1)));  // off on expiry
        steps.push_back(idc(sn(8'h42, 1'b0, 7'h60, 1'b0)));
        steps.push_back(idc(sn(8'h42, 1'b0, 7'h60, 1'b0)));
        steps.push_back(tx(8'h42));
        steps.push_back(txc(8'h10, sn(8'h42, 1'b1, 7'h10, 1'b1)));
        steps.push_back(tx(8'h43));
        steps.push_back(txc(8'h11, sn(8'h43, 1'b0, 7'h11, 1'b1)));
        steps.push_back(idc(sn(8'h43, 1'b0, 7'h11, 1'b0)));
        steps.push_back(idc(sn(8'h43, 1'b0, 7'h11, 1'b0)));
        steps.push_back(idc(sn(8'h43, 1'b1, 7'h11, 1'b0)));
        steps.push_back(idc(sn(8'h43, 1'b1, 7'h11, 1'b0)));
        foreach (steps[i]) begin
            rx_data  = steps[i].d;
            rx_valid = steps[i].v;
            if (steps[i].chk) sb.push_back(steps[i].want);
            @(negedge clk);
            rx_valid = 1'b0;
            if (steps[i].chk) begin
                want = sb.pop_front();
                got  = obs_b();
                n_checks++;
                if (got !== want) begin
                    n_errors++;
                    $display("FAIL back_to_back step %0d: got note=%h gate=%b vel=%h ev=%b, expected note=%h gate=%b vel=%h ev=%b",
                             i, got.note, got.gate, got.vel, got.ev, want.note, want.gate, want.vel, want.ev);
                end
            end
        end
    endtask

    // -------------------------------------------------------------------------
    initial begin
        test_reset();
        test_note_on();
        test_running_status();
        test_last_note();
        test_realtime();
        test_channel();
        test_parser_edges();
        test_async_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
